hpdcache_mem_read_responder: RTL

- Memory-side responder for the HPDcache miss/refill read interface: the memory end of the read request channel.
- Accepts read requests (address, length, size, transaction ID) over a valid/ready handshake.
- Returns cache-line data as a burst of response beats after a fixed latency, reading from an internal word array.
- Used as the memory model in block- and subsystem-level benches, and as an on-chip scratch backing store in standalone configurations.

---
 rtl/hpdcache_mem_resp_pkg.sv | 38 +++
 rtl/hpdcache_mem_req_fifo.sv | 73 +++++++
 rtl/hpdcache_mem_read_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_mem_resp_pkg
// Description : Shared types for the HPDcache memory read responder.
//               - mem_req_entry_t : one queued read request {addr, len, size, id}
//               - resp_state_e    : responder FSM states
//               - BEAT_BYTES_LOG2 : address shift for the default 128-bit beat
//               - beat_bytes_log2 : same shift for any beat width
// Revision    : 1.0 - initial release
// ============================================================================
package hpdcache_mem_resp_pkg;

  // Queue entries are sized for the widest supported configuration so that one
  // struct serves every parameterisation; narrower fields are zero-extended.
  localparam int unsigned MAX_PA_WIDTH           = 64;
  localparam int unsigned MAX_ID_WIDTH           = 16;
  localparam int unsigned DEFAULT_MEM_DATA_WIDTH = 128;
  localparam int unsigned BEAT_BYTES_LOG2        = $clog2(DEFAULT_MEM_DATA_WIDTH / 8);

  typedef struct packed {
    logic [MAX_PA_WIDTH-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [MAX_ID_WIDTH-1:0] id;
  } mem_req_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } resp_state_e;

  function automatic int unsigned beat_bytes_log2(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_mem_req_fifo
// Description : Synchronous FIFO holding pending read requests. Head entry is
//               presented combinationally on rdata_o; count is registered.
// Ports       : clk_i, rst_i        clock / sync active-high reset
//               push_i, wdata_i     write side (ignored when full)
//               pop_i, rdata_o      read side (ignored when empty)
//               full_o, empty_o     status
//               count_o             number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_mem_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_mem_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_mem_read_responder
// Description : Memory end of the HPDcache read request channel. Queues read
//               requests, and after a fixed latency returns len+1 beats read
//               from an internal word array. Out-of-range or wrongly-sized
//               beats are flagged with error and carry zero data.
// Ports       : clk_i, rst_i                 clock / sync active-high reset
//               mem_req_read_*               request channel (valid/ready)
//               mem_resp_read_*              response channel (valid/ready)
//               init_we_i/addr_i/wdata_i     backdoor array write
// Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_mem_read_responder
  import hpdcache_mem_resp_pkg::*;
#(
  parameter int unsigned PA_WIDTH       = 49,
  parameter int unsigned MEM_DATA_WIDTH = 128,
  parameter int unsigned MEM_ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned REQ_FIFO_DEPTH = 4,
  parameter int unsigned LATENCY        = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,

  input  logic                          mem_req_read_valid_i,
  output logic                          mem_req_read_ready_o,
  input  logic [PA_WIDTH-1:0]           mem_req_read_addr_i,
  input  logic [7:0]                    mem_req_read_len_i,
  input  logic [2:0]                    mem_req_read_size_i,
  input  logic [MEM_ID_WIDTH-1:0]       mem_req_read_id_i,

  output logic                          mem_resp_read_valid_o,
  input  logic                          mem_resp_read_ready_i,
  output logic [MEM_DATA_WIDTH-1:0]     mem_resp_read_data_o,
  output logic [MEM_ID_WIDTH-1:0]       mem_resp_read_id_o,
  output logic                          mem_resp_read_last_o,
  output logic                          mem_resp_read_error_o,

  input  logic                          init_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]  init_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0]     init_wdata_i
);

  localparam int unsigned BEAT_SHIFT = beat_bytes_log2(MEM_DATA_WIDTH);
  localparam int unsigned DEPTH_LOG2 = $clog2(MEM_DEPTH);
  localparam int unsigned WORD_W     = PA_WIDTH - BEAT_SHIFT;
  // One extra bit so addr+beat_cnt cannot silently wrap past the top.
  localparam int unsigned IDX_W      = WORD_W + 1;
  localparam int unsigned LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned ENTRY_W    = $bits(mem_req_entry_t);
  localparam int unsigned CNT_W      = $clog2(REQ_FIFO_DEPTH) + 1;

  // --------------------------------------------------------------------------
  // Request queue
  // --------------------------------------------------------------------------
  mem_req_entry_t      req_entry;
  mem_req_entry_t      head_entry;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [CNT_W-1:0]    fifo_count;

  assign req_entry = '{
    addr: MAX_PA_WIDTH'(mem_req_read_addr_i),
    len:  mem_req_read_len_i,
    size: mem_req_read_size_i,
    id:   MAX_ID_WIDTH'(mem_req_read_id_i)
  };
  assign head_entry = mem_req_entry_t'(fifo_rdata);

  // Ready depends on registered FIFO state only; a simultaneous pop does not
  // open a slot for the same cycle.
  assign mem_req_read_ready_o = !fifo_full;
  assign fifo_push            = mem_req_read_valid_i && !fifo_full;

  hpdcache_mem_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (req_entry),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Backing array (not reset, survives rst_i)
  // --------------------------------------------------------------------------
  logic [MEM_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (init_we_i) begin
      mem_q[init_addr_i] <= init_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Burst state
  // --------------------------------------------------------------------------
  resp_state_e               state_q,  state_d;
  mem_req_entry_t            cur_q,    cur_d;
  logic [LAT_W-1:0]          lat_q,    lat_d;
  logic [7:0]                beat_q,   beat_d;
  logic                      valid_q,  valid_d;
  logic [MEM_DATA_WIDTH-1:0] data_q,   data_d;
  logic [MEM_ID_WIDTH-1:0]   id_q,     id_d;
  logic                      last_q,   last_d;
  logic                      err_q,    err_d;

  logic [WORD_W-1:0]         cur_word;
  logic [IDX_W-1:0]          beat_idx;
  logic                      idx_oob;
  logic                      size_err;
  logic                      beat_err;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;
  logic                      launch;

  assign cur_word  = cur_q.addr[PA_WIDTH-1:BEAT_SHIFT];
  assign beat_idx  = IDX_W'(cur_word) + IDX_W'(beat_q);
  // Any set bit above the array index means the word lies beyond MEM_DEPTH.
  assign idx_oob   = |beat_idx[IDX_W-1:DEPTH_LOG2];
  assign size_err  = (cur_q.size != 3'(BEAT_SHIFT));
  assign beat_err  = idx_oob || size_err;
  // Array read sees the pre-edge contents, so a same-cycle backdoor write to
  // this word is only visible to later launches.
  assign mem_rdata = mem_q[beat_idx[DEPTH_LOG2-1:0]];

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    data_d   = data_q;
    id_d     = id_q;
    last_d   = last_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = head_entry;
          lat_d    = LAT_W'(LATENCY - 1);
          beat_d   = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          launch  = 1'b1;
          state_d = BURST;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      BURST: begin
        if (valid_q && mem_resp_read_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            launch = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      valid_d = 1'b1;
      id_d    = cur_q.id[MEM_ID_WIDTH-1:0];
      last_d  = (beat_q == cur_q.len);
      err_d   = beat_err;
      data_d  = beat_err ? '0 : mem_rdata;
      // Stop counting on the final beat so len=255 never wraps the counter.
      if (beat_q != cur_q.len) begin
        beat_d = beat_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign mem_resp_read_valid_o = valid_q;
  assign mem_resp_read_data_o  = data_q;
  assign mem_resp_read_id_o    = id_q;
  assign mem_resp_read_last_o  = last_q;
  assign mem_resp_read_error_o = err_q;

  // Address offset bits, unused upper struct bits and the queue count are
  // intentionally not consumed.
  logic unused_bits;
  assign unused_bits = ^{cur_q.addr, cur_q.id, fifo_count};

endmodule
`default_nettype wire
